conv_window3x3: RTL and testbench

Builds 3x3 convolution windows from the padded pixel stream that the padding stage emits. It sits directly downstream of padding and directly upstream of the conv/MAC array. It accepts one CHANNEL-wide pixel per valid strobe in raster order over a W×W padded frame, with W = SIZE+2·PADDING. For every pixel whose 3x3 neighbourhood lies fully inside the frame, it emits one registered 9-pixel window, so each frame produces (W−2)² windows.

---
 rtl/nn_pkg.sv | 13 +
 rtl/line_shift.sv | 33 +++
 rtl/conv_window3x3.sv | 110 +++++++++++
 tb/tb_conv_window3x3.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared constants and helpers for the padding / window / conv pipeline.
package nn_pkg;

    localparam int unsigned N         = 8;
    localparam int unsigned CHANNEL   = 3;
    localparam int unsigned WIN_SLOTS = 9;

    // Bit offset of window slot k (k = r*3 + c) for a pixel of pix_w bits.
    function automatic int unsigned slot_offset(input int unsigned k, input int unsigned pix_w);
        return k * pix_w;
    endfunction

endpackage

// File: rtl/line_shift.sv
// Enabled shift register line buffer; dout_o is the entry shifted in DEPTH enables ago.
module line_shift #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o
);

    logic [DEPTH-1:0][WIDTH-1:0] data_q;
    logic [DEPTH-1:0][WIDTH-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (en_i) begin
            data_d = {data_q[DEPTH-2:0], din_i};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign dout_o = data_q[DEPTH-1];

endmodule

// File: rtl/conv_window3x3.sv
// Builds 3x3 pixel windows from a padded raster stream; one registered window per
// pixel whose full neighbourhood lies inside the frame.
module conv_window3x3
    import nn_pkg::*;
#(
    parameter int unsigned N       = nn_pkg::N,
    parameter int unsigned CHANNEL = nn_pkg::CHANNEL,
    parameter int unsigned SIZE    = 32,
    parameter int unsigned PADDING = 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 ce,
    input  logic                                 din_vld,
    input  logic [CHANNEL*N-1:0]                 din,
    output logic [nn_pkg::WIN_SLOTS*CHANNEL*N-1:0] win_dout,
    output logic                                 win_vld,
    output logic                                 win_end
);

    localparam int unsigned W  = SIZE + 2 * PADDING;
    localparam int unsigned PW = CHANNEL * N;
    localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

    logic [CW-1:0] col_q, col_d;
    logic [CW-1:0] row_q, row_d;

    // Packed [row][col] so slot r*3+c lands at bit (r*3+c)*PW with no repacking.
    logic [2:0][2:0][PW-1:0] win_q, win_d;
    logic [2:0][2:0][PW-1:0] dout_q, dout_d;
    logic                    vld_q, vld_d;
    logic                    end_q, end_d;

    logic                    accept_c;
    logic [PW-1:0]           line0_out;
    logic [PW-1:0]           line1_out;

    assign accept_c = ce & din_vld;

    line_shift #(.WIDTH(PW), .DEPTH(W)) u_line0 (
        .clk    (clk),
        .rst    (rst),
        .en_i   (accept_c),
        .din_i  (din),
        .dout_o (line0_out)
    );

    line_shift #(.WIDTH(PW), .DEPTH(W)) u_line1 (
        .clk    (clk),
        .rst    (rst),
        .en_i   (accept_c),
        .din_i  (line0_out),
        .dout_o (line1_out)
    );

    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        win_d  = win_q;
        dout_d = dout_q;
        vld_d  = 1'b0;
        end_d  = 1'b0;

        if (!ce) begin
            col_d = '0;
            row_d = '0;
        end else if (din_vld) begin
            if (col_q == CW'(W - 1)) begin
                col_d = '0;
                row_d = (row_q == CW'(W - 1)) ? '0 : row_q + CW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end

            // Shift left; new right column is two-rows-up, one-row-up, current.
            win_d[0] = {line1_out, win_q[0][2:1]};
            win_d[1] = {line0_out, win_q[1][2:1]};
            win_d[2] = {din,       win_q[2][2:1]};

            if ((row_q >= CW'(2)) && (col_q >= CW'(2))) begin
                vld_d  = 1'b1;
                end_d  = (row_q == CW'(W - 1)) && (col_q == CW'(W - 1));
                dout_d = win_d;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q  <= '0;
            row_q  <= '0;
            win_q  <= '0;
            dout_q <= '0;
            vld_q  <= 1'b0;
            end_q  <= 1'b0;
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            win_q  <= win_d;
            dout_q <= dout_d;
            vld_q  <= vld_d;
            end_q  <= end_d;
        end
    end

    assign win_dout = dout_q;
    assign win_vld  = vld_q;
    assign win_end  = end_q;

endmodule

// File: tb/tb_conv_window3x3.sv
// Scoreboard bench for conv_window3x3 at W=5, one 8-bit channel.
`timescale 1ns/1ps
module tb_conv_window3x3;
    import nn_pkg::*;

    localparam int unsigned TN  = 8;
    localparam int unsigned TCH = 1;
    localparam int unsigned TW  = 5;
    localparam int unsigned WW  = 9 * TN * TCH;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ce = 1'b0;
    logic          din_vld = 1'b0;
    logic [7:0]    din = '0;
    logic [WW-1:0] win_dout;
    logic          win_vld;
    logic          win_end;

    conv_window3x3 #(.N(TN), .CHANNEL(TCH), .SIZE(3), .PADDING(1)) dut (
        .clk      (clk),
        .rst      (rst),
        .ce       (ce),
        .din_vld  (din_vld),
        .din      (din),
        .win_dout (win_dout),
        .win_vld  (win_vld),
        .win_end  (win_end)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WW-1:0] d;
        logic          e;
        int            cyc;
    } exp_t;

    exp_t          exp_q[$];
    logic [WW-1:0] obs_q[$];
    int            n_end = 0;
    int            total = 0;
    int            bad   = 0;
    int            cyc   = 0;

    // Reference model: current frame image and raster position of the next pixel.
    int unsigned   img [TW][TW];
    int            mr = 0;
    int            mc = 0;

    always @(posedge clk) cyc++;

    function automatic logic [WW-1:0] pk(input int unsigned v [9]);
        logic [WW-1:0] r;
        r = '0;
        for (int k = 0; k < 9; k++) r[slot_offset(k, TN) +: TN] = TN'(v[k]);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [WW-1:0] got, input logic [WW-1:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endtask

    task automatic model_accept(input logic [7:0] v);
        exp_t          e;
        int unsigned   s [9];
        img[mr][mc] = v;
        if (mr >= 2 && mc >= 2) begin
            for (int k = 0; k < 9; k++) s[k] = img[mr - 2 + k / 3][mc - 2 + k % 3];
            e.d   = pk(s);
            e.e   = (mr == TW - 1) && (mc == TW - 1);
            e.cyc = cyc + 1;
            exp_q.push_back(e);
        end
        mc++;
        if (mc == TW) begin
            mc = 0;
            mr = (mr == TW - 1) ? 0 : mr + 1;
        end
    endtask

    // Drive one cycle (called just after a rising edge) and keep the model in step.
    task automatic drive(input logic c, input logic v, input logic [7:0] d);
        ce = c; din_vld = v; din = d;
        if (!c) begin
            mr = 0; mc = 0;
        end else if (v) begin
            model_accept(d);
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 8'h00);
    endtask

    task automatic frame(input int base, input int max_gap);
        for (int i = 0; i < 25; i++) begin
            drive(1'b1, 1'b1, 8'(base + i));
            if (max_gap > 0) idle(int'($urandom_range(max_gap, 0)));
        end
    endtask

    task automatic start_scn();
        obs_q.delete();
        n_end = 0;
    endtask

    function automatic logic [WW-1:0] obs_at(input int i);
        return (i < obs_q.size()) ? obs_q[i] : 'x;
    endfunction

    task automatic end_scn(input string nm, input int n, input int ne,
                           input logic [WW-1:0] first, input logic [WW-1:0] last);
        idle(3);
        chk({nm, "_count"}, WW'(obs_q.size()), WW'(n));
        chk({nm, "_ends"}, WW'(n_end), WW'(ne));
        chk({nm, "_first"}, obs_at(0), first);
        chk({nm, "_last"}, obs_at(n - 1), last);
        chk({nm, "_pending"}, WW'(exp_q.size()), WW'(0));
    endtask

    // Monitor: pop and compare on every presented window.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (win_end && !win_vld) begin
                total++; bad++;
                $display("FAIL end_without_vld got=1 want=0");
            end
            if (win_vld) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_win got=%h want=none", win_dout);
                end else begin
                    e = exp_q.pop_front();
                    if ({win_end, win_dout} !== {e.e, e.d}) begin
                        bad++;
                        $display("FAIL win_data got end=%0b data=%h want end=%0b data=%h",
                                 win_end, win_dout, e.e, e.d);
                    end
                    total++;
                    if (cyc != e.cyc) begin
                        bad++;
                        $display("FAIL win_time got=%0d want=%0d", cyc, e.cyc);
                    end
                end
                obs_q.push_back(win_dout);
                if (win_end) n_end++;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WW-1:0] w_first, w_last, w_f2;
        w_first = pk('{0, 1, 2, 5, 6, 7, 10, 11, 12});
        w_last  = pk('{12, 13, 14, 17, 18, 19, 22, 23, 24});
        w_f2    = pk('{100, 101, 102, 105, 106, 107, 110, 111, 112});

        #1;
        chk("reset_vld", WW'(win_vld), WW'(0));
        chk("reset_end", WW'(win_end), WW'(0));
        chk("reset_dout", win_dout, '0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        idle(2);

        start_scn();
        frame(0, 0);
        end_scn("contig", 9, 1, w_first, w_last);

        start_scn();
        frame(0, 13);
        end_scn("gapped", 9, 1, w_first, w_last);

        start_scn();
        frame(0, 0);
        frame(100, 0);
        idle(3);
        chk("b2b_f2_first", obs_at(9), w_f2);
        end_scn("b2b", 18, 2, w_first, pk('{112, 113, 114, 117, 118, 119, 122, 123, 124}));

        start_scn();
        for (int i = 0; i <= 14; i++) drive(1'b1, 1'b1, 8'(i));
        rst = 1'b1;
        exp_q.delete();
        mr = 0; mc = 0;
        #1;
        chk("rst_mid_vld", WW'(win_vld), WW'(0));
        chk("rst_mid_end", WW'(win_end), WW'(0));
        chk("rst_mid_dout", win_dout, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(1);
        start_scn();
        frame(0, 0);
        end_scn("rst_replay", 9, 1, w_first, w_last);

        start_scn();
        for (int i = 0; i <= 8; i++) drive(1'b1, 1'b1, 8'(i));
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 8'($urandom_range(255, 0)));
        frame(0, 0);
        end_scn("ce_low", 9, 1, w_first, w_last);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
